picorv32_membus: RTL and testbench
==================================

Name: picorv32_membus

Overview:
Parametrised memory/IO fabric between the picorv32 native bus and three targets: internal RAM, 8-bit external RAM and the 8-bit peripheral bus, plus a byte-wide programming port into internal RAM. It replaces the fixed always-ready decode with a handshaked FSM. The FSM adds configurable wait states, full 32-bit assembly of external-RAM reads, and byte-lane sequencing of external writes.

Parameters:
MEM_WORDS, 1024, internal RAM depth in 32-bit words; power of two.
MEM_INIT, "", hex init file for internal RAM; empty means no init.
EXTRAM_AW, 16, external RAM byte address width; range 2..16.
EXTRAM_WAIT, 1, extra cycles each external byte strobe is held; range 0..15.
PERIPH_WAIT, 0, extra cycles the peripheral strobe is held; range 0..15.
PROG_AW, 16, programming port byte address width.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
mem_valid  in  1  CPU request
mem_ready  out  1  one-cycle transaction completion
mem_addr  in  32  CPU byte address
mem_wdata  in  32  CPU write data
mem_wstrb  in  4  byte enables; 0 means read
mem_rdata  out  32  read data, valid while mem_ready=1
prog_en  in  1  programming port owns internal RAM
prog_we  in  1  programming write request
prog_re  in  1  programming read request
prog_addr  in  PROG_AW  programming byte address
prog_wdata  in  8  programming write byte
prog_rdata  out  8  programming read byte, valid with prog_ack
prog_ack  out  1  one-cycle programming access done
extram_a  out  EXTRAM_AW  external byte address
extram_d_in  in  8  external read data
extram_d_out  out  8  external write data
extram_cs, extram_oe, extram_we  out  1 each  external strobes
periph_addr  out  6  peripheral register index (mem_addr[7:2])
periph_wdata  out  8  mem_wdata[7:0]
periph_rdata  in  8  peripheral read data
periph_cs, periph_oe, periph_we  out  1 each  peripheral strobes

Behaviour:
- Decode: addr[31]=0 targets IRAM at word mem_addr>>2, modulo MEM_WORDS. addr[31]=1 with addr[16]=0 targets EXTRAM. addr[31]=1 with addr[16]=1 targets PERIPH.
- FSM states: IDLE, IRAM, XBYTE, PBYTE, DONE, PROG.
- Reset: FSM to IDLE. mem_ready, prog_ack, all cs/oe/we strobes go 0. mem_rdata and prog_rdata go 0. extram_a goes 0. RAM contents are retained.
- Reset mid-transaction: strobes are low in the cycle after rst is sampled. No mem_ready is issued for the aborted transaction.
- Accept rule: in IDLE, prog_en=1 has priority. If prog_en=0 and mem_valid=1, the transaction is accepted; call that cycle T. Request inputs are latched at T.
- Handshake: mem_ready is high exactly one cycle per transaction; that cycle is the DONE state. The next transaction can be accepted at DONE+1 at the earliest.
- IRAM read: RAM read at T; mem_ready and data at T+1.
- IRAM write: bytes with set wstrb bits are written at the T clock edge; mem_ready at T+1.
- EXTRAM lane sequencing: lanes are processed 0..3, i.e. extram_a = {addr[AW-1:2], lane}.
- EXTRAM read: all four lanes. Each byte cycle holds cs=oe=1 for EXTRAM_WAIT+1 cycles. extram_d_in is sampled in the last cycle of each byte cycle into rdata[8*lane+:8], assembling a little-endian word.
- EXTRAM write: only lanes with set wstrb bits; clear lanes are skipped with zero cycles. cs=we=1 and d_out=wdata[8*lane+:8] for each executed byte cycle.
- EXTRAM timing: lane k of n executed lanes is strobed over T+1+k(W+1) .. T+k(W+1)+W+1. mem_ready is at T+1+n(W+1), with n=4 for reads.
- PERIPH: cs plus oe or we held T+1..T+1+PERIPH_WAIT.
- PERIPH read: periph_rdata is sampled in the last strobe cycle and returned replicated {4{byte}}. mem_ready at T+2+PERIPH_WAIT.
- Strobe gaps: strobes drop to 0 in DONE. There is no gap between consecutive external byte cycles; cs stays high across lanes.
- PROG: in IDLE with prog_en=1 and prog_we or prog_re, one access to byte prog_addr of IRAM (word prog_addr>>2, lane prog_addr[1:0]). prog_ack and prog_rdata follow the next cycle.
- PROG conflicts: if prog_we and prog_re are both set, the write wins and prog_rdata returns the old byte. prog_en rising mid-CPU-transaction does nothing until that transaction's DONE. While prog_en=1, mem_valid is not accepted and mem_ready stays 0.
- Widths: extram_a drops high address bits beyond EXTRAM_AW. An out-of-range IRAM index wraps modulo MEM_WORDS.

Test Plan:
- IRAM: write 0xDEADBEEF with wstrb=0xF to 0x100, then read -> mem_ready one cycle after each accept; read returns 0xDEADBEEF.
- EXTRAM, EXTRAM_WAIT=1, byte model 0x11,0x22,0x33,0x44 at 0x0..0x3: read 0x80000000 -> 4 lanes each oe 2 cycles; mem_ready at T+9; rdata=0x44332211.
- EXTRAM write wstrb=0b1010 at 0x80000004, wdata=0xAABBCCDD -> exactly two byte cycles: a=5/d=0xCC, then a=7/d=0xAA; mem_ready at T+5.
- PERIPH, PERIPH_WAIT=2: read 0x80010008 -> periph_addr=2; oe held 3 cycles; periph_rdata=0x5A gives mem_rdata=0x5A5A5A5A at T+4.
- PROG: prog_en=1, write 0x7E to byte 6, then read byte 6 -> prog_ack each next cycle; prog_rdata=0x7E; mem_valid raised meanwhile gets no mem_ready.
- Reset: assert rst during the second external lane -> all strobes 0 next cycle; no mem_ready; a new read after reset completes normally.

Source files
------------

// File: rtl/picorv32_membus_if.sv
// picorv32 native memory bus bundle: the CPU drives the request and the fabric answers.
interface picorv32_membus_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (output mem_valid, mem_addr, mem_wdata, mem_wstrb,
                    input  mem_ready, mem_rdata);
    modport slave  (input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
                    output mem_ready, mem_rdata);
endinterface

// File: rtl/picorv32_membus.sv
// Handshaked fabric from the picorv32 bus to internal RAM, byte-wide external RAM and the
// peripheral bus, plus a byte programming port into internal RAM.
module picorv32_membus #(
    parameter int MEM_WORDS   = 1024,
    parameter     MEM_INIT    = "",
    parameter int EXTRAM_AW   = 16,
    parameter int EXTRAM_WAIT = 1,
    parameter int PERIPH_WAIT = 0,
    parameter int PROG_AW     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    picorv32_membus_if.slave     bus,
    input  logic                 prog_en,
    input  logic                 prog_we,
    input  logic                 prog_re,
    input  logic [PROG_AW-1:0]   prog_addr,
    input  logic [7:0]           prog_wdata,
    output logic [7:0]           prog_rdata,
    output logic                 prog_ack,
    output logic [EXTRAM_AW-1:0] extram_a,
    input  logic [7:0]           extram_d_in,
    output logic [7:0]           extram_d_out,
    output logic                 extram_cs,
    output logic                 extram_oe,
    output logic                 extram_we,
    output logic [5:0]           periph_addr,
    output logic [7:0]           periph_wdata,
    input  logic [7:0]           periph_rdata,
    output logic                 periph_cs,
    output logic                 periph_oe,
    output logic                 periph_we
);
    localparam int IW = $clog2(MEM_WORDS);

    typedef enum logic [2:0] {S_IDLE, S_IRAM, S_XBYTE, S_PBYTE, S_DONE, S_PROG} state_t;

    function automatic logic [1:0] low_lane(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    state_t               state_q, state_d;
    logic [31:0]          addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic                 is_wr_q, is_wr_d, src_iram_q, src_iram_d;
    logic [1:0]           lane_q, lane_d, prog_lane_q, prog_lane_d;
    logic [3:0]           pend_q, pend_d, wait_q, wait_d;
    logic                 mem_ready_q, mem_ready_d, prog_ack_q, prog_ack_d;
    logic                 xcs_q, xcs_d, xoe_q, xoe_d, xwe_q, xwe_d;
    logic [EXTRAM_AW-1:0] xa_q, xa_d;
    logic [7:0]           xd_q, xd_d;
    logic                 pcs_q, pcs_d, poe_q, poe_d, pwe_q, pwe_d;

    logic [31:0]   prog_a32, x_first_full, x_next_full;
    logic [3:0]    start_mask;
    logic [1:0]    first_lane, next_lane;
    logic          req_wr;
    logic [IW-1:0] ram_idx;
    logic [3:0]    ram_we;
    logic [31:0]   ram_wd, ram_rd_q;
    logic [31:0]   ram_mem [MEM_WORDS];

    assign prog_a32     = 32'(prog_addr);
    assign req_wr       = |bus.mem_wstrb;
    assign start_mask   = req_wr ? bus.mem_wstrb : 4'hF;
    assign first_lane   = low_lane(start_mask);
    assign next_lane    = low_lane(pend_q);
    assign x_first_full = {bus.mem_addr[31:2], first_lane};
    assign x_next_full  = {addr_q[31:2], next_lane};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        is_wr_d     = is_wr_q;
        src_iram_d  = src_iram_q;
        lane_d      = lane_q;
        prog_lane_d = prog_lane_q;
        pend_d      = pend_q;
        wait_d      = wait_q;
        mem_ready_d = 1'b0;
        prog_ack_d  = 1'b0;
        xcs_d       = xcs_q;
        xoe_d       = xoe_q;
        xwe_d       = xwe_q;
        xa_d        = xa_q;
        xd_d        = xd_q;
        pcs_d       = pcs_q;
        poe_d       = poe_q;
        pwe_d       = pwe_q;
        ram_idx     = bus.mem_addr[IW+1:2];
        ram_we      = 4'b0;
        ram_wd      = bus.mem_wdata;
        case (state_q)
            S_IDLE: begin
                if (prog_en) begin
                    ram_idx = prog_a32[IW+1:2];
                    ram_wd  = {4{prog_wdata}};
                    if (prog_we || prog_re) begin
                        ram_we      = prog_we ? (4'b1 << prog_a32[1:0]) : 4'b0;
                        prog_lane_d = prog_a32[1:0];
                        prog_ack_d  = 1'b1;
                        state_d     = S_PROG;
                    end
                end else if (bus.mem_valid) begin
                    addr_d     = bus.mem_addr;
                    wdata_d    = bus.mem_wdata;
                    is_wr_d    = req_wr;
                    rdata_d    = 32'h0;
                    src_iram_d = !bus.mem_addr[31];
                    if (!bus.mem_addr[31]) begin
                        // Internal RAM completes straight from the accept edge.
                        ram_we      = bus.mem_wstrb;
                        mem_ready_d = 1'b1;
                        state_d     = S_DONE;
                    end else if (!bus.mem_addr[16]) begin
                        lane_d  = first_lane;
                        pend_d  = start_mask & ~(4'b1 << first_lane);
                        wait_d  = 4'(EXTRAM_WAIT);
                        xcs_d   = 1'b1;
                        xoe_d   = !req_wr;
                        xwe_d   = req_wr;
                        xa_d    = x_first_full[EXTRAM_AW-1:0];
                        xd_d    = bus.mem_wdata[{first_lane, 3'b000} +: 8];
                        state_d = S_XBYTE;
                    end else begin
                        wait_d  = 4'(PERIPH_WAIT);
                        pcs_d   = 1'b1;
                        poe_d   = !req_wr;
                        pwe_d   = req_wr;
                        state_d = S_PBYTE;
                    end
                end
            end
            S_XBYTE: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    if (!is_wr_q) rdata_d[{lane_q, 3'b000} +: 8] = extram_d_in;
                    if (pend_q == 4'b0) begin
                        mem_ready_d = 1'b1;
                        xcs_d       = 1'b0;
                        xoe_d       = 1'b0;
                        xwe_d       = 1'b0;
                        state_d     = S_DONE;
                    end else begin
                        // Chain straight into the next lane so cs never drops between bytes.
                        lane_d = next_lane;
                        pend_d = pend_q & ~(4'b1 << next_lane);
                        wait_d = 4'(EXTRAM_WAIT);
                        xa_d   = x_next_full[EXTRAM_AW-1:0];
                        xd_d   = wdata_q[{next_lane, 3'b000} +: 8];
                    end
                end
            end
            S_PBYTE: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    if (!is_wr_q) rdata_d = {4{periph_rdata}};
                    mem_ready_d = 1'b1;
                    pcs_d       = 1'b0;
                    poe_d       = 1'b0;
                    pwe_d       = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_IRAM:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_PROG:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (rst) ram_we = 4'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            is_wr_q     <= 1'b0;
            src_iram_q  <= 1'b0;
            lane_q      <= '0;
            prog_lane_q <= '0;
            pend_q      <= '0;
            wait_q      <= '0;
            mem_ready_q <= 1'b0;
            prog_ack_q  <= 1'b0;
            xcs_q       <= 1'b0;
            xoe_q       <= 1'b0;
            xwe_q       <= 1'b0;
            xa_q        <= '0;
            xd_q        <= '0;
            pcs_q       <= 1'b0;
            poe_q       <= 1'b0;
            pwe_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            is_wr_q     <= is_wr_d;
            src_iram_q  <= src_iram_d;
            lane_q      <= lane_d;
            prog_lane_q <= prog_lane_d;
            pend_q      <= pend_d;
            wait_q      <= wait_d;
            mem_ready_q <= mem_ready_d;
            prog_ack_q  <= prog_ack_d;
            xcs_q       <= xcs_d;
            xoe_q       <= xoe_d;
            xwe_q       <= xwe_d;
            xa_q        <= xa_d;
            xd_q        <= xd_d;
            pcs_q       <= pcs_d;
            poe_q       <= poe_d;
            pwe_q       <= pwe_d;
        end
    end

    // Read-first RAM: a simultaneous programming write and read returns the old byte.
    always_ff @(posedge clk) begin
        ram_rd_q <= ram_mem[ram_idx];
        for (int b = 0; b < 4; b++) begin
            if (ram_we[b]) ram_mem[ram_idx][8*b +: 8] <= ram_wd[8*b +: 8];
        end
    end

    assign bus.mem_ready = mem_ready_q;
    assign bus.mem_rdata = mem_ready_q ? (src_iram_q ? ram_rd_q : rdata_q) : 32'h0;
    assign prog_ack      = prog_ack_q;
    assign prog_rdata    = prog_ack_q ? ram_rd_q[{prog_lane_q, 3'b000} +: 8] : 8'h00;
    assign extram_a      = xa_q;
    assign extram_d_out  = xd_q;
    assign extram_cs     = xcs_q;
    assign extram_oe     = xoe_q;
    assign extram_we     = xwe_q;
    assign periph_addr   = addr_q[7:2];
    assign periph_wdata  = wdata_q[7:0];
    assign periph_cs     = pcs_q;
    assign periph_oe     = poe_q;
    assign periph_we     = pwe_q;

    logic unused_bits;
    assign unused_bits = ^{bus.mem_addr, prog_a32, addr_q, x_first_full, x_next_full};
endmodule

// File: tb/tb_picorv32_membus.sv
// Scoreboard bench for picorv32_membus: CPU transactions queue their expected data and
// latency, a negedge monitor pops and compares them on mem_ready.
module tb_picorv32_membus;
    localparam int XW = 1;
    localparam int PW = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog_en = 1'b0, prog_we = 1'b0, prog_re = 1'b0;
    logic [15:0] prog_addr = '0;
    logic [7:0]  prog_wdata = '0;
    logic [7:0]  prog_rdata;
    logic        prog_ack;
    logic [15:0] extram_a;
    logic [7:0]  extram_d_in, extram_d_out;
    logic        extram_cs, extram_oe, extram_we;
    logic [5:0]  periph_addr;
    logic [7:0]  periph_wdata, periph_rdata;
    logic        periph_cs, periph_oe, periph_we;

    picorv32_membus_if bus();

    picorv32_membus #(.MEM_WORDS(1024), .EXTRAM_AW(16), .EXTRAM_WAIT(XW),
                      .PERIPH_WAIT(PW), .PROG_AW(16)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .prog_en(prog_en), .prog_we(prog_we), .prog_re(prog_re), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .prog_rdata(prog_rdata), .prog_ack(prog_ack),
        .extram_a(extram_a), .extram_d_in(extram_d_in), .extram_d_out(extram_d_out),
        .extram_cs(extram_cs), .extram_oe(extram_oe), .extram_we(extram_we),
        .periph_addr(periph_addr), .periph_wdata(periph_wdata), .periph_rdata(periph_rdata),
        .periph_cs(periph_cs), .periph_oe(periph_oe), .periph_we(periph_we)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rdy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // External RAM model: data is only valid once the address has been held one full cycle,
    // so sampling before the last cycle of a byte strobe reads 0xEE.
    logic [7:0]  xmem [65536];
    logic        hist_oe = 1'b0;
    logic [15:0] hist_a = '0;
    int          poe_cnt = 0;
    always @(posedge clk) begin
        hist_oe <= extram_oe && extram_cs;
        hist_a  <= extram_a;
        poe_cnt <= periph_oe ? poe_cnt + 1 : 0;
    end
    assign extram_d_in  = (extram_oe && hist_oe && hist_a == extram_a) ? xmem[extram_a] : 8'hEE;
    assign periph_rdata = (periph_oe && poe_cnt == PW) ? 8'h5A : 8'h33;

    logic [23:0] xw_log[$];
    logic [15:0] xr_log[$];
    logic [5:0]  pr_log[$];
    always @(negedge clk) begin
        if (extram_cs && extram_we) begin
            xw_log.push_back({extram_a, extram_d_out});
            xmem[extram_a] = extram_d_out;
        end
        if (extram_cs && extram_oe) xr_log.push_back(extram_a);
        if (periph_cs && periph_oe) pr_log.push_back(periph_addr);
    end

    typedef struct packed {
        logic [31:0] rdata;
        logic        chk;
        logic [15:0] lat;
        logic [31:0] t0;
    } exp_t;
    exp_t  sb[$];
    string sb_tag[$];
    exp_t  e_mon;
    string t_mon;

    always @(negedge clk) begin
        if (bus.mem_ready) begin
            rdy_cnt++;
            if (sb.size() == 0) begin
                check("spurious_ready", {31'b0, bus.mem_ready}, 32'd0);
            end else begin
                e_mon = sb.pop_front();
                t_mon = sb_tag.pop_front();
                check({t_mon, "_lat"}, 32'(cyc) - e_mon.t0, 32'(e_mon.lat));
                if (e_mon.chk) check({t_mon, "_rdata"}, bus.mem_rdata, e_mon.rdata);
            end
        end
    end

    task automatic push_exp(input string tag, input logic [31:0] rd, input bit chk, input int lat);
        exp_t e;
        e.rdata = rd;
        e.chk   = chk;
        e.lat   = 16'(lat);
        e.t0    = 32'(cyc);
        sb.push_back(e);
        sb_tag.push_back(tag);
    endtask

    task automatic cpu_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic [31:0] exp_rd, input bit chk,
                           input int lat);
        int n;
        push_exp(tag, exp_rd, chk, lat);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = wstrb;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.mem_ready && n < 60);
        if (!bus.mem_ready) check({tag, "_timeout"}, {31'b0, bus.mem_ready}, 32'd1);
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'b0;
        @(negedge clk);
        check({tag, "_pulse"}, {31'b0, bus.mem_ready}, 32'd0);
    endtask

    task automatic prog_access(input string tag, input logic we, input logic re,
                               input logic [15:0] a, input logic [7:0] wd,
                               input logic [7:0] exp_rd, input bit chk);
        prog_we    = we;
        prog_re    = re;
        prog_addr  = a;
        prog_wdata = wd;
        @(negedge clk);
        check({tag, "_ack"}, {31'b0, prog_ack}, 32'd1);
        if (chk) check({tag, "_rdata"}, {24'b0, prog_rdata}, {24'b0, exp_rd});
        prog_we = 1'b0;
        prog_re = 1'b0;
        @(negedge clk);
        check({tag, "_ack_pulse"}, {31'b0, prog_ack}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, required finished");
        $fatal(1, "watchdog");
    end

    logic [23:0] exp_w [4];
    int n;
    int rdy_before;

    initial begin
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        for (int i = 0; i < 8; i++) xmem[i] = 8'h11 * 8'(i + 1);
        exp_w[0] = {16'h0005, 8'hCC};
        exp_w[1] = {16'h0005, 8'hCC};
        exp_w[2] = {16'h0007, 8'hAA};
        exp_w[3] = {16'h0007, 8'hAA};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", {31'b0, bus.mem_ready}, 32'd0);
        check("rst_rdata", bus.mem_rdata, 32'h0);
        check("rst_strobes", {26'b0, extram_cs, extram_oe, extram_we, periph_cs, periph_oe, periph_we}, 32'd0);
        check("rst_extram_a", {16'b0, extram_a}, 32'd0);
        check("rst_prog", {23'b0, prog_ack, prog_rdata}, 32'd0);
        @(negedge clk);

        // Internal RAM: full write, read, partial write, wrap-around alias.
        cpu_txn("iram_wr", 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1);
        cpu_txn("iram_rd", 32'h0000_0100, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1, 1);
        cpu_txn("iram_wrap_wr", 32'h0000_1100, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 1);
        cpu_txn("iram_wrap_rd", 32'h0000_0100, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b1, 1);
        cpu_txn("iram_part_wr", 32'h0000_0100, 32'h1234_5678, 4'b0011, 32'h0, 1'b0, 1);
        cpu_txn("iram_part_rd", 32'h0000_0100, 32'h0, 4'h0, 32'hCAFE_5678, 1'b1, 1);
        cpu_txn("iram_w4", 32'h0000_0004, 32'h1122_3344, 4'hF, 32'h0, 1'b0, 1);

        // External RAM read: four lanes of two cycles each.
        xr_log.delete();
        cpu_txn("xram_rd", 32'h8000_0000, 32'h0, 4'h0, 32'h4433_2211, 1'b1, 1 + 4 * (XW + 1));
        check("xram_rd_cycles", 32'(xr_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < xr_log.size(); i++)
            check($sformatf("xram_rd_a%0d", i), {16'b0, xr_log[i]}, 32'(i / 2));

        // External RAM sparse write: lanes 1 and 3 only.
        xw_log.delete();
        cpu_txn("xram_wr", 32'h8000_0004, 32'hAABB_CCDD, 4'b1010, 32'h0, 1'b0, 1 + 2 * (XW + 1));
        check("xram_wr_cycles", 32'(xw_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < xw_log.size(); i++)
            check($sformatf("xram_wr_ad%0d", i), {8'b0, xw_log[i]}, {8'b0, exp_w[i]});
        cpu_txn("xram_rd2", 32'h8000_0004, 32'h0, 4'h0, 32'hAA77_CC55, 1'b1, 1 + 4 * (XW + 1));
        cpu_txn("xram_alias", 32'h8002_0000, 32'h0, 4'h0, 32'h4433_2211, 1'b1, 1 + 4 * (XW + 1));

        // Peripheral read with replicated byte.
        pr_log.delete();
        cpu_txn("periph_rd", 32'h8001_0008, 32'h0, 4'h0, 32'h5A5A_5A5A, 1'b1, 2 + PW);
        check("periph_oe_cycles", 32'(pr_log.size()), 32'(PW + 1));
        if (pr_log.size() > 0) check("periph_addr", {26'b0, pr_log[0]}, 32'd2);

        // Programming port, with a CPU request pending that must be ignored.
        rdy_before = rdy_cnt;
        prog_en = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0000_0100;
        bus.mem_wstrb = 4'h0;
        prog_access("prog_wr", 1'b1, 1'b0, 16'd6, 8'h7E, 8'h00, 1'b0);
        prog_access("prog_rd", 1'b0, 1'b1, 16'd6, 8'h00, 8'h7E, 1'b1);
        prog_access("prog_wr_rd", 1'b1, 1'b1, 16'd6, 8'h55, 8'h7E, 1'b1);
        prog_access("prog_rd2", 1'b0, 1'b1, 16'd6, 8'h00, 8'h55, 1'b1);
        repeat (3) @(negedge clk);
        check("prog_blocks_cpu", 32'(rdy_cnt - rdy_before), 32'd0);
        bus.mem_valid = 1'b0;
        @(negedge clk);
        prog_en = 1'b0;
        @(negedge clk);
        cpu_txn("iram_after_prog", 32'h0000_0004, 32'h0, 4'h0, 32'h1155_3344, 1'b1, 1);

        // Reset during the second external lane.
        rdy_before = rdy_cnt;
        push_exp("xram_abort", 32'h0, 1'b0, 0);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h8000_0000;
        bus.mem_wstrb = 4'h0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(extram_cs && extram_a == 16'd1) && n < 30);
        check("abort_lane1_seen", {16'b0, extram_a}, 32'd1);
        rst = 1'b1;
        bus.mem_valid = 1'b0;
        sb.delete();
        sb_tag.delete();
        @(negedge clk);
        check("abort_strobes", {29'b0, extram_cs, extram_oe, extram_we}, 32'd0);
        check("abort_ready", {31'b0, bus.mem_ready}, 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_ready", 32'(rdy_cnt - rdy_before), 32'd0);
        cpu_txn("xram_rd_post_rst", 32'h8000_0000, 32'h0, 4'h0, 32'h4433_2211, 1'b1, 1 + 4 * (XW + 1));

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
